// File: rtl/sim_exit_pkg.sv
// sim_exit_pkg: shared definitions for the simulation-control peripheral.
//   - Register byte offsets of the 16-byte window
//   - Read value for write-only / unmapped locations
//   - Exit code reported on watchdog timeout
//   - Exit FSM state type
package sim_exit_pkg;

  localparam int unsigned EXIT_OFS    = 32'h0;
  localparam int unsigned CONSOLE_OFS = 32'h4;
  localparam int unsigned STATUS_OFS  = 32'h8;
  localparam int unsigned CYCLE_OFS   = 32'hC;

  localparam logic [31:0] BAD_READ          = 32'hDEADBEEF;
  localparam logic [31:0] EXIT_TIMEOUT_CODE = 32'd255;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } exit_state_e;

endpackage

// File: rtl/sim_exit_fifo.sv
// sim_exit_fifo: synchronous FIFO buffering console bytes.
// Ports:
//   clk      - clock
//   rst_n    - asynchronous active-low reset (empties the FIFO)
//   i_push   - write i_data (ignored when full)
//   i_data   - write data
//   i_pop    - drop head entry (ignored when empty)
//   o_data   - head entry, valid while !o_empty
//   o_full   - no free entries
//   o_empty  - no stored entries
// DEPTH must be a power of two and >= 2.
module sim_exit_fifo #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_data,
  output logic              o_full,
  output logic              o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]       r_wptr;
  logic [AW:0]       r_rptr;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_push;
  logic              w_pop;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage needs no reset; entries are only visible once written.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/sim_exit_dev.sv
// sim_exit_dev: memory-mapped simulation-control peripheral.
// Harts write exit codes (0x0) and console bytes (0x4); STATUS (0x8) shows the
// per-hart done mask and fail latch; CYCLE (0xC) is a free-running counter.
// Once every hart is done or a failure is latched, the console FIFO is
// drained and then exit/exitcode are raised and held until reset.
// Ports:
//   clk, resetn                     - clock, asynchronous active-low reset
//   req_valid/ready/we/addr/wdata   - bus request (ready low only on a push to a full FIFO)
//   req_hart                        - issuing hart id
//   resp_valid/resp_rdata           - one-cycle response, one per accepted request
//   con_valid/con_ready/con_data    - console byte stream
//   exit/exitcode                   - sticky finish flag and code (0 = pass)
// Build option: define SIM_EXIT_WDT_EN to enable the watchdog, which forces an
// exit with code 255 after WDT_CYCLES cycles without finishing.
module sim_exit_dev
  import sim_exit_pkg::*;
#(
  parameter int unsigned NHARTS     = 4,
  parameter int unsigned HART_W     = 2,
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned CON_DEPTH  = 8,
  parameter int unsigned WDT_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [HART_W-1:0] req_hart,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              con_valid,
  input  logic              con_ready,
  output logic [7:0]        con_data,
  output logic              exit,
  output logic [31:0]       exitcode
);

  exit_state_e       r_state, w_state_d;
  logic [NHARTS-1:0] r_done, w_done_d;
  logic              r_fail, w_fail_d;
  logic [31:0]       r_code, w_code_d;
  logic [31:0]       r_cycle;
  logic              r_resp_valid;
  logic [31:0]       r_resp_rdata;

  logic              w_sel_exit, w_sel_con, w_sel_status, w_sel_cycle;
  logic              w_accept;
  logic              w_exit_wr;
  logic              w_con_wr;
  logic              w_hart_ok;
  logic              w_fifo_full, w_fifo_empty;
  logic              w_con_pop;
  logic [31:0]       w_status;
  logic [31:0]       w_rdata;
  logic              w_wdt_expire;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  assign w_sel_exit   = (req_addr == ADDR_W'(EXIT_OFS));
  assign w_sel_con    = (req_addr == ADDR_W'(CONSOLE_OFS));
  assign w_sel_status = (req_addr == ADDR_W'(STATUS_OFS));
  assign w_sel_cycle  = (req_addr == ADDR_W'(CYCLE_OFS));

  // Full is the registered flag, so a pop in this cycle never frees room for
  // a push in the same cycle.
  assign req_ready = !(req_valid && req_we && w_sel_con && w_fifo_full);
  assign w_accept  = req_valid && req_ready;
  assign w_exit_wr = w_accept && req_we && w_sel_exit;
  assign w_con_wr  = w_accept && req_we && w_sel_con;
  assign w_hart_ok = (32'(req_hart) < NHARTS);

  // ---------------------------------------------------------------------------
  // Console FIFO
  // ---------------------------------------------------------------------------
  assign con_valid = !w_fifo_empty;
  assign w_con_pop = con_valid && con_ready;

  sim_exit_fifo #(
    .DEPTH  (CON_DEPTH),
    .DATA_W (8)
  ) u_con_fifo (
    .clk     (clk),
    .rst_n   (resetn),
    .i_push  (w_con_wr),
    .i_data  (req_wdata[7:0]),
    .i_pop   (w_con_pop),
    .o_data  (con_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
`ifdef SIM_EXIT_WDT_EN
  localparam int unsigned WDT_W = $clog2(WDT_CYCLES + 1);

  logic [WDT_W-1:0] r_wdt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wdt <= '0;
    end else if (r_state != DONE) begin
      r_wdt <= r_wdt + 1'b1;
    end
  end

  // Fires on the cycle whose closing edge is the WDT_CYCLES-th since reset.
  assign w_wdt_expire = (r_state != DONE) && (r_wdt == WDT_W'(WDT_CYCLES - 1));
`else
  assign w_wdt_expire = 1'b0;

  // Watchdog compiled out: WDT_CYCLES has no effect in this build.
  if (WDT_CYCLES == 0) begin : g_wdt_unused
  end
`endif

  // ---------------------------------------------------------------------------
  // Done mask, fail latch and exit FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    w_done_d  = r_done;
    w_fail_d  = r_fail;
    w_code_d  = r_code;
    w_state_d = r_state;

    // Only the first EXIT write from each hart counts; none count after DONE.
    if (w_exit_wr && w_hart_ok && (r_state != DONE) && !r_done[req_hart]) begin
      w_done_d[req_hart] = 1'b1;
      if ((req_wdata != 32'd0) && !r_fail) begin
        w_fail_d = 1'b1;
        w_code_d = req_wdata;
      end
    end

    if (w_wdt_expire) begin
      w_fail_d = 1'b1;
      w_code_d = EXIT_TIMEOUT_CODE;
    end

    // RUN looks at the next-state mask so the final write starts the drain
    // without an extra cycle of latency.
    unique case (r_state)
      RUN:     if ((&w_done_d) || w_fail_d) w_state_d = DRAIN;
      DRAIN:   if (w_fifo_empty) w_state_d = DONE;
      DONE:    w_state_d = DONE;
      default: w_state_d = RUN;
    endcase

    // Timeout skips the drain.
    if (w_wdt_expire) w_state_d = DONE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= RUN;
      r_done  <= '0;
      r_fail  <= 1'b0;
      r_code  <= '0;
    end else begin
      r_state <= w_state_d;
      r_done  <= w_done_d;
      r_fail  <= w_fail_d;
      r_code  <= w_code_d;
    end
  end

  assign exit     = (r_state == DONE);
  assign exitcode = (exit && r_fail) ? r_code : 32'd0;

  // ---------------------------------------------------------------------------
  // Cycle counter and read response
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cycle <= '0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
    end
  end

  always_comb begin
    w_status               = '0;
    w_status[NHARTS-1:0]   = r_done;
    w_status[31]           = r_fail;
  end

  always_comb begin
    w_rdata = BAD_READ;
    if (w_sel_status)     w_rdata = w_status;
    else if (w_sel_cycle) w_rdata = r_cycle;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      r_resp_valid <= w_accept;
      r_resp_rdata <= (w_accept && !req_we) ? w_rdata : 32'd0;
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;

endmodule

// File: tb/tb_sim_exit_dev.sv
// tb_sim_exit_dev: directed self-checking bench for sim_exit_dev.
module tb_sim_exit_dev;

  logic        clk;
  logic        resetn;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [3:0]  req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_hart;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        con_valid;
  logic        con_ready;
  logic [7:0]  con_data;
  logic        exit;
  logic [31:0] exitcode;

  int n_total = 0;
  int n_bad   = 0;
  logic [7:0] con_q[$];

  sim_exit_dev #(
    .NHARTS     (4),
    .HART_W     (2),
    .ADDR_W     (4),
    .CON_DEPTH  (8),
    .WDT_CYCLES (50)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_hart   (req_hart),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .con_valid  (con_valid),
    .con_ready  (con_ready),
    .con_data   (con_data),
    .exit       (exit),
    .exitcode   (exitcode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Collect every byte handed to the console sink.
  always @(posedge clk) begin
    if (resetn && con_valid && con_ready) con_q.push_back(con_data);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_hart  = '0;
    con_ready = 1'b1;
    resetn    = 1'b0;
    repeat (2) @(negedge clk);
    con_q.delete();
    resetn = 1'b1;
  endtask

  // One request: drive at negedge, wait for ready, accept at posedge, check the
  // response at the following negedge.
  task automatic bus(input logic we, input logic [3:0] addr, input logic [31:0] wd,
                     input logic [1:0] hart, output logic [31:0] rd);
    int n;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    req_hart  = hart;
    #1;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n == 100) chk("ready_timeout", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("resp_valid", 32'(resp_valid), 32'd1);
    rd = resp_rdata;
    if (we) chk("wr_rdata_zero", rd, 32'd0);
  endtask

  logic [31:0] rd;
  logic [31:0] c0;

  initial begin
    resetn = 1'b0;
    do_reset();

    // Reset state
    chk("rst_exit", 32'(exit), 32'd0);
    chk("rst_exitcode", exitcode, 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_con_valid", 32'(con_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);

    // All harts pass
    for (int h = 0; h < 4; h++) bus(1'b1, 4'h0, 32'd0, 2'(h), rd);
    chk("pass_exit_early", 32'(exit), 32'd0);
    @(negedge clk);
    chk("pass_exit", 32'(exit), 32'd1);
    chk("pass_exitcode", exitcode, 32'd0);
    bus(1'b0, 4'h8, 32'd0, 2'd0, rd);
    chk("pass_status", rd, 32'h0000000F);

    // First failure wins; later writes after DONE ignored
    do_reset();
    bus(1'b1, 4'h0, 32'd7, 2'd2, rd);
    chk("fail_exit_early", 32'(exit), 32'd0);
    @(negedge clk);
    chk("fail_exit", 32'(exit), 32'd1);
    chk("fail_exitcode", exitcode, 32'd7);
    bus(1'b1, 4'h0, 32'd9, 2'd1, rd);
    chk("fail_exitcode_keep", exitcode, 32'd7);
    bus(1'b0, 4'h8, 32'd0, 2'd0, rd);
    chk("fail_status", rd, 32'h80000004);

    // Console backpressure and ordering
    do_reset();
    con_ready = 1'b0;
    for (int i = 0; i < 8; i++) bus(1'b1, 4'h4, 32'h41 + 32'(i), 2'd0, rd);
    chk("con_head", 32'(con_data), 32'h41);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 4'h4;
    req_wdata = 32'h49;
    #1;
    chk("con_full_ready", 32'(req_ready), 32'd0);
    con_ready = 1'b1;
    #1;
    chk("con_no_bypass", 32'(req_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("con_ready_after_pop", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("con_9th_resp", 32'(resp_valid), 32'd1);
    repeat (12) @(negedge clk);
    chk("con_count", 32'(con_q.size()), 32'd9);
    for (int i = 0; i < 9 && i < con_q.size(); i++)
      chk("con_byte", 32'(con_q[i]), 32'h41 + 32'(i));
    chk("con_no_exit", 32'(exit), 32'd0);

    // Drain before exit
    do_reset();
    con_ready = 1'b0;
    for (int i = 0; i < 3; i++) bus(1'b1, 4'h4, 32'h78 + 32'(i), 2'd0, rd);
    for (int h = 0; h < 4; h++) bus(1'b1, 4'h0, 32'd0, 2'(h), rd);
    repeat (3) @(negedge clk);
    chk("drain_hold", 32'(exit), 32'd0);
    con_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("drain_empty", 32'(con_valid), 32'd0);
    chk("drain_exit_early", 32'(exit), 32'd0);
    @(negedge clk);
    chk("drain_exit", 32'(exit), 32'd1);
    chk("drain_exitcode", exitcode, 32'd0);

    // Back-to-back reads, misc reads, reset mid-transaction
    do_reset();
    bus(1'b1, 4'h0, 32'd0, 2'd0, rd);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 4'h8;
    @(posedge clk);
    @(negedge clk);
    chk("b2b_valid0", 32'(resp_valid), 32'd1);
    chk("b2b_status", resp_rdata, 32'h00000001);
    req_addr = 4'hA;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("b2b_valid1", 32'(resp_valid), 32'd1);
    chk("b2b_bad", resp_rdata, 32'hDEADBEEF);
    @(negedge clk);
    chk("b2b_idle", 32'(resp_valid), 32'd0);
    bus(1'b0, 4'h0, 32'd0, 2'd0, rd);
    chk("rd_exit_bad", rd, 32'hDEADBEEF);
    bus(1'b0, 4'h4, 32'd0, 2'd0, rd);
    chk("rd_con_bad", rd, 32'hDEADBEEF);
    bus(1'b1, 4'hC, 32'h1234, 2'd0, rd);
    bus(1'b0, 4'hC, 32'd0, 2'd0, c0);
    bus(1'b0, 4'hC, 32'd0, 2'd0, rd);
    chk("cycle_delta", rd - c0, 32'd2);
    con_ready = 1'b0;
    bus(1'b1, 4'h4, 32'h55, 2'd0, rd);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 4'hC;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("mid_resp_pre", 32'(resp_valid), 32'd1);
    resetn = 1'b0;
    #1;
    chk("mid_resp_valid", 32'(resp_valid), 32'd0);
    chk("mid_resp_rdata", resp_rdata, 32'd0);
    chk("mid_con_valid", 32'(con_valid), 32'd0);
    chk("mid_exit", 32'(exit), 32'd0);
    chk("mid_exitcode", exitcode, 32'd0);

    // Watchdog
    do_reset();
`ifdef SIM_EXIT_WDT_EN
    repeat (49) @(posedge clk);
    #1;
    chk("wdt_early", 32'(exit), 32'd0);
    @(posedge clk);
    #1;
    chk("wdt_exit", 32'(exit), 32'd1);
    chk("wdt_exitcode", exitcode, 32'd255);
    bus(1'b0, 4'h8, 32'd0, 2'd0, rd);
    chk("wdt_status", rd, 32'h80000000);
`else
    repeat (1000) @(negedge clk);
    chk("no_wdt_exit", 32'(exit), 32'd0);
    chk("no_wdt_exitcode", exitcode, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
